// File: rtl/dff_bank_ctrl.sv
// dff_bank_ctrl: sequences PRE/CLR pulses and capture strobes for a bank of
// preset/clear D flip-flops, and keeps a shadow copy of the bank contents.
// Outputs are registered from the next-state decode, so req never reaches a
// bank drive combinationally.
module dff_bank_ctrl #(
  parameter int WIDTH      = 4,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic             req,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] value,
  input  logic [WIDTH-1:0] bank_d,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] bank_pre,
  output logic [WIDTH-1:0] bank_clr,
  output logic             bank_clk_en,
  output logic [WIDTH-1:0] shadow,
  output logic             shadow_valid
);

  localparam int CW = $clog2(PULSE_CYC + SETTLE_CYC + 2);

  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] P_LAST   = CW'(PULSE_CYC);
  localparam logic [CW-1:0] S_LAST   = CW'(SETTLE_CYC);

  localparam logic [1:0] OP_CLEAR   = 2'd0;
  localparam logic [1:0] OP_PRESET  = 2'd1;
  localparam logic [1:0] OP_LOAD    = 2'd2;
  localparam logic [1:0] OP_CAPTURE = 2'd3;

  localparam logic [2:0] ST_INIT    = 3'd0;
  localparam logic [2:0] ST_IDLE    = 3'd1;
  localparam logic [2:0] ST_ASSERT  = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_SETTLE  = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  // With no recovery time the pulse phases skip straight to DONE.
  localparam logic [2:0]    ST_AFTER_PULSE  = (SETTLE_CYC > 0) ? ST_SETTLE : ST_DONE;
  localparam logic [CW-1:0] CNT_AFTER_PULSE = (SETTLE_CYC > 0) ? CNT_ONE : CNT_ZERO;

  logic [2:0]       state, n_state;
  logic [CW-1:0]    cnt, n_cnt;
  logic [1:0]       cmd, n_cmd;
  logic [WIDTH-1:0] val, n_val;
  logic             armed, n_armed;
  logic             init_op;

  logic [WIDTH-1:0] n_pre, n_clr, shadow_upd;
  logic             n_clk_en, n_done, n_ready;

  // Next-state logic; cycle 0 of every phase (cnt=0) is a setup cycle with drives low.
  always_comb begin
    n_state = state;
    n_cnt   = cnt;
    n_cmd   = cmd;
    n_val   = val;
    n_armed = armed;
    case (state)
      ST_INIT: begin
        if (!armed) begin
          n_armed = 1'b1;
          n_cnt   = CNT_ZERO;
        end else if (cnt == P_LAST) begin
          n_state = ST_AFTER_PULSE;
          n_cnt   = CNT_AFTER_PULSE;
        end else begin
          n_cnt = cnt + CNT_ONE;
        end
      end
      ST_IDLE: begin
        if (req && ready) begin
          n_cmd   = op;
          n_val   = value;
          n_cnt   = CNT_ZERO;
          n_state = (op == OP_CAPTURE) ? ST_CAPTURE : ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (cnt == P_LAST) begin
          n_state = ST_AFTER_PULSE;
          n_cnt   = CNT_AFTER_PULSE;
        end else begin
          n_cnt = cnt + CNT_ONE;
        end
      end
      ST_CAPTURE: begin
        if (cnt == CNT_ONE) begin
          n_state = ST_AFTER_PULSE;
          n_cnt   = CNT_AFTER_PULSE;
        end else begin
          n_cnt = cnt + CNT_ONE;
        end
      end
      ST_SETTLE: begin
        if (cnt == S_LAST) begin
          n_state = ST_DONE;
          n_cnt   = CNT_ZERO;
        end else begin
          n_cnt = cnt + CNT_ONE;
        end
      end
      ST_DONE: begin
        n_state = ST_IDLE;
        n_cnt   = CNT_ZERO;
      end
      default: begin
        n_state = ST_INIT;
        n_cnt   = CNT_ZERO;
      end
    endcase
  end

  // Output decode of the upcoming state; PRE and CLR patterns are disjoint by construction.
  always_comb begin
    n_pre    = '0;
    n_clr    = '0;
    n_clk_en = (n_state == ST_CAPTURE) && (n_cnt == CNT_ONE);
    n_done   = (n_state == ST_DONE) && !init_op;
    n_ready  = (n_state == ST_IDLE);
    if (n_state == ST_INIT && n_cnt != CNT_ZERO) begin
      n_clr = '1;
    end else if (n_state == ST_ASSERT && n_cnt != CNT_ZERO) begin
      case (n_cmd)
        OP_CLEAR:  n_clr = '1;
        OP_PRESET: n_pre = '1;
        OP_LOAD: begin
          n_pre = n_val;
          n_clr = ~n_val;
        end
        default: begin
          n_pre = '0;
          n_clr = '0;
        end
      endcase
    end
  end

  // Shadow contents that the bank holds once the current command completes.
  always_comb begin
    shadow_upd = '0;
    if (!init_op) begin
      case (cmd)
        OP_CLEAR:   shadow_upd = '0;
        OP_PRESET:  shadow_upd = '1;
        OP_LOAD:    shadow_upd = val;
        OP_CAPTURE: shadow_upd = bank_d;
        default:    shadow_upd = '0;
      endcase
    end
  end

  // State, command and output registers; reset drops every drive at once.
  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      state        <= ST_INIT;
      cnt          <= CNT_ZERO;
      cmd          <= OP_CLEAR;
      val          <= '0;
      armed        <= 1'b0;
      init_op      <= 1'b1;
      bank_pre     <= '0;
      bank_clr     <= '0;
      bank_clk_en  <= 1'b0;
      done         <= 1'b0;
      ready        <= 1'b0;
      shadow       <= '0;
      shadow_valid <= 1'b0;
    end else begin
      state       <= n_state;
      cnt         <= n_cnt;
      cmd         <= n_cmd;
      val         <= n_val;
      armed       <= n_armed;
      bank_pre    <= n_pre;
      bank_clr    <= n_clr;
      bank_clk_en <= n_clk_en;
      done        <= n_done;
      ready       <= n_ready;
      if (state == ST_DONE) begin
        shadow       <= shadow_upd;
        shadow_valid <= 1'b1;
        init_op      <= 1'b0;
      end
    end
  end

endmodule
